// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming popcount neuron.
// Provides the frame FSM state type, the sum width rule and the input mask builder.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest input vector the mask builder supports.
    localparam int MASK_MAX = 1024;

    // Bits needed to hold WIDTH*BEATS, the largest possible frame sum.
    function automatic int sum_w(input int width, input int beats);
        return $clog2(width * beats + 1);
    endfunction

    // All ones, with the low 'drop' bits cleared when approximating.
    function automatic logic [MASK_MAX-1:0] build_mask(
        input int   drop,
        input logic approx
    );
        logic [MASK_MAX-1:0] m;
        m = '1;
        if (approx) begin
            m = m << drop;
        end
        return m;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational adder-tree popcount of a WIDTH-bit vector (exact baseline).
// Ports: in_bits (WIDTH) -> count ($clog2(WIDTH+1)).
module popcount_tree #(
    parameter int WIDTH = 27,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] in_bits,
    output logic [OUT_W-1:0] count
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign count = OUT_W'(in_bits);
        end else begin : g_node
            localparam int LO_W  = WIDTH / 2;
            localparam int HI_W  = WIDTH - LO_W;
            localparam int LO_CW = $clog2(LO_W + 1);
            localparam int HI_CW = $clog2(HI_W + 1);

            logic [LO_CW-1:0] lo_cnt;
            logic [HI_CW-1:0] hi_cnt;

            popcount_tree #(.WIDTH(LO_W)) u_lo (
                .in_bits (in_bits[LO_W-1:0]),
                .count   (lo_cnt)
            );

            popcount_tree #(.WIDTH(HI_W)) u_hi (
                .in_bits (in_bits[WIDTH-1:LO_W]),
                .count   (hi_cnt)
            );

            assign count = OUT_W'(lo_cnt) + OUT_W'(hi_cnt);
        end
    endgenerate

endmodule

// File: rtl/popcount_stream_neuron.sv
// Accumulates the popcount of up to BEATS input beats per frame and emits the
// sum plus a threshold activation. Ports: beat stream (input_a/in_valid/
// in_last/in_ready), frame config (approx_en/thresh), result (out_valid/
// out_ready/popcount_out/neuron_out).
module popcount_stream_neuron
    import popcount_pkg::*;
#(
    parameter int WIDTH       = 27,
    parameter int BEATS       = 4,
    parameter int APPROX_DROP = 4,
    parameter int SUM_W       = sum_w(WIDTH, BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             approx_en,
    input  logic [SUM_W-1:0] thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] popcount_out,
    output logic             neuron_out
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int CNT_W = $clog2(BEATS + 1);

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               approx_q, approx_d;
    logic [SUM_W-1:0]   thresh_q, thresh_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   pop_q, pop_d;
    logic               neuron_q, neuron_d;

    logic               approx_sel;
    logic [SUM_W-1:0]   thresh_sel;
    logic [WIDTH-1:0]   masked;
    logic [PC_W-1:0]    pc;
    logic               accept;
    logic               close;
    logic [SUM_W-1:0]   acc_next;

    // The first beat uses the live config, which is also what gets latched.
    assign approx_sel = (state_q == IDLE) ? approx_en : approx_q;
    assign thresh_sel = (state_q == IDLE) ? thresh : thresh_q;
    assign masked     = input_a & WIDTH'(build_mask(APPROX_DROP, approx_sel));

    popcount_tree #(.WIDTH(WIDTH)) u_tree (
        .in_bits (masked),
        .count   (pc)
    );

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        approx_d    = approx_q;
        thresh_d    = thresh_q;
        out_valid_d = out_valid_q;
        pop_d       = pop_q;
        neuron_d    = neuron_q;
        close       = 1'b0;
        acc_next    = acc_q + SUM_W'(pc);

        unique case (state_q)
            IDLE: begin
                acc_next = SUM_W'(pc);
                if (accept) begin
                    approx_d = approx_en;
                    thresh_d = thresh;
                    acc_d    = acc_next;
                    cnt_d    = CNT_W'(1);
                    close    = in_last || (BEATS == 1);
                    state_d  = ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    close = in_last || (cnt_q == CNT_W'(BEATS - 1));
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (close) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            pop_d       = acc_next;
            neuron_d    = (acc_next >= thresh_sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            approx_q    <= 1'b0;
            thresh_q    <= '0;
            out_valid_q <= 1'b0;
            pop_q       <= '0;
            neuron_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            approx_q    <= approx_d;
            thresh_q    <= thresh_d;
            out_valid_q <= out_valid_d;
            pop_q       <= pop_d;
            neuron_q    <= neuron_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign popcount_out = pop_q;
    assign neuron_out   = neuron_q;

endmodule

// File: tb/tb_popcount_stream_neuron.sv
// Self-checking bench for popcount_stream_neuron: frame-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_popcount_stream_neuron;

    localparam int WIDTH = 27;
    localparam int BEATS = 4;
    localparam int DROP  = 4;
    localparam int SW    = 7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] input_a = '0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             approx_en = 1'b0;
    logic [SW-1:0]    thresh = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SW-1:0]    popcount_out;
    logic             neuron_out;

    popcount_stream_neuron dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .approx_en    (approx_en),
        .thresh       (thresh),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .popcount_out (popcount_out),
        .neuron_out   (neuron_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level model state.
    bit m_open, m_done, m_apx, m_neu;
    int m_sum, m_cnt, m_thr, m_pop;

    task automatic model_reset();
        m_open = 0; m_done = 0; m_apx = 0; m_neu = 0;
        m_sum = 0; m_cnt = 0; m_thr = 0; m_pop = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] full;
        logic [WIDTH-1:0] mask;
        full = '1;
        if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (in_valid) begin
            if (!m_open) begin
                m_apx = approx_en;
                m_thr = int'(thresh);
                m_sum = 0;
                m_cnt = 0;
                m_open = 1;
            end
            mask = m_apx ? (full << DROP) : full;
            m_sum += $countones(input_a & mask);
            m_cnt++;
            if (in_last || m_cnt == BEATS) begin
                m_open = 0;
                m_done = 1;
                m_pop = m_sum;
                m_neu = (m_sum >= m_thr);
            end
        end
    endtask

    task automatic compare_all();
        check("in_ready", int'(in_ready), int'(!m_done));
        check("out_valid", int'(out_valid), int'(m_done));
        check("popcount_out", int'(popcount_out), m_pop);
        check("neuron_out", int'(neuron_out), int'(m_neu));
    endtask

    // One clock: drive, clock edge, advance the model, compare just after.
    task automatic cyc(input bit v, input bit last, input logic [WIDTH-1:0] a,
                       input bit apx, input int thr, input bit ordy);
        in_valid  = v;
        in_last   = last;
        input_a   = a;
        approx_en = apx;
        thresh    = SW'(thr);
        out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drain();
        cyc(0, 0, '0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        #2;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset popcount", int'(popcount_out), 0);
        check("reset neuron", int'(neuron_out), 0);
        #1 rst = 1'b0;

        // Full exact frame.
        cyc(1, 0, 27'h7FFFFFF, 0, 100, 0);
        cyc(1, 0, 27'h7FFFFFF, 0, 100, 0);
        cyc(1, 0, 27'h7FFFFFF, 0, 100, 0);
        check("t1 no early valid", int'(out_valid), 0);
        cyc(1, 0, 27'h7FFFFFF, 0, 100, 0);
        check("t1 valid", int'(out_valid), 1);
        check("t1 sum", int'(popcount_out), 108);
        check("t1 neuron", int'(neuron_out), 1);
        drain();

        // Early termination.
        cyc(1, 0, 27'h0000007, 0, 8, 0);
        cyc(1, 1, 27'h00000F0, 0, 8, 0);
        check("t2 sum", int'(popcount_out), 7);
        check("t2 neuron", int'(neuron_out), 0);
        cyc(1, 0, 27'h1, 0, 8, 0);
        check("t2 in_ready low", int'(in_ready), 0);
        drain();
        check("t2 released", int'(in_ready), 1);

        // Approximate vs exact single-beat frames.
        cyc(1, 1, 27'h000000F, 1, 0, 0);
        check("t3 approx sum", int'(popcount_out), 0);
        check("t3 approx neuron", int'(neuron_out), 1);
        drain();
        cyc(1, 1, 27'h000000F, 0, 0, 0);
        check("t3 exact sum", int'(popcount_out), 4);
        drain();

        // Backpressure with config churn.
        cyc(1, 1, 27'h00000FF, 0, 5, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(i % 2, 1, 27'h7FFFFFF, i % 2, i * 9, 0);
            check("t4 held sum", int'(popcount_out), 8);
        end
        drain();
        cyc(1, 1, 27'h00000FF, 1, 5, 0);
        check("t4 new cfg sum", int'(popcount_out), 4);
        check("t4 new cfg neuron", int'(neuron_out), 0);
        drain();

        // Asynchronous reset mid-frame.
        cyc(1, 0, 27'h7FFFFFF, 0, 3, 0);
        cyc(1, 0, 27'h7FFFFFF, 0, 3, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t5 in_ready", int'(in_ready), 1);
        check("t5 out_valid", int'(out_valid), 0);
        check("t5 popcount", int'(popcount_out), 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1, 0, 27'h1, 0, 3, 0);
        check("t5 fresh sum", int'(popcount_out), 4);
        drain();

        // Threshold boundary, with gaps inside ACC.
        cyc(1, 0, 27'h7FFFFFF, 0, 54, 0);
        cyc(0, 1, 27'h7FFFFFF, 0, 0, 0);
        cyc(0, 0, 27'h7FFFFFF, 0, 0, 0);
        cyc(1, 1, 27'h7FFFFFF, 0, 0, 0);
        check("t6 sum", int'(popcount_out), 54);
        check("t6 neuron eq", int'(neuron_out), 1);
        drain();
        cyc(1, 0, 27'h7FFFFFF, 0, 55, 0);
        cyc(0, 0, '0, 0, 0, 0);
        cyc(1, 1, 27'h7FFFFFF, 0, 0, 0);
        check("t6 neuron below", int'(neuron_out), 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7,
                $urandom_range(0, 3) == 0,
                WIDTH'($urandom),
                1'($urandom),
                int'($urandom_range(0, 108)),
                1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
